// File: rtl/obj_fsm_multi.sv
// Multi-channel object detector: per-channel debounce/hold FSMs plus registered
// aggregate flags (count, any, lowest active index) aligned with the object vector.

module obj_fsm_ch #(
    parameter int DEB_CYCLES  = 2,
    parameter int HOLD_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_det,
    input  logic i_en,
    output logic o_obj_nxt,
    output logic o_obj,
    output logic o_rise
);
    localparam int CMAX = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;

    typedef enum logic [1:0] {IDLE, CONFIRM, PRESENT, HOLD} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt, w_cnt_sat;
    logic [8:0] w_cnt_inc;
    logic       w_rise_nxt;

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_cnt_sat = (w_cnt_inc > 9'(CMAX)) ? 8'(CMAX) : w_cnt_inc[7:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                IDLE: if (i_det) begin
                    if (DEB_CYCLES == 1) begin
                        w_state_nxt = PRESENT;
                        w_cnt_nxt   = 8'd0;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = CONFIRM;
                        w_cnt_nxt   = 8'd1;
                    end
                end
                CONFIRM: if (i_det) begin
                    if (w_cnt_inc == 9'(DEB_CYCLES)) begin
                        w_state_nxt = PRESENT;
                        w_cnt_nxt   = 8'd0;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_sat;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end
                PRESENT: if (!i_det) begin
                    if (HOLD_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = 8'd1;
                    end
                end
                HOLD: if (i_det) begin
                    // Re-acquire during hold is the same object: no rise pulse.
                    w_state_nxt = PRESENT;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == 8'(HOLD_CYCLES)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    assign o_obj_nxt = (w_state_nxt == PRESENT) || (w_state_nxt == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            o_obj   <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            o_obj   <= o_obj_nxt;
            o_rise  <= w_rise_nxt;
        end
    end
endmodule

module obj_fsm_multi #(
    parameter int N_CH        = 3,
    parameter int DEB_CYCLES  = 2,
    parameter int HOLD_CYCLES = 3,
    localparam int CW = $clog2(N_CH + 1),
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] det,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] object,
    output logic [N_CH-1:0] obj_rise,
    output logic [CW-1:0]   obj_count,
    output logic            any_object,
    output logic [IW-1:0]   first_idx
);
    logic [N_CH-1:0] w_obj_nxt;
    logic [CW-1:0]   w_count, r_count;
    logic [IW-1:0]   w_first, r_first;
    logic            r_any;

    obj_fsm_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch [N_CH-1:0] (
        .clk      (clk),
        .reset    (reset),
        .i_det    (det),
        .i_en     (ch_en),
        .o_obj_nxt(w_obj_nxt),
        .o_obj    (object),
        .o_rise   (obj_rise)
    );

    // Aggregates come from the next-state vector so they register alongside object.
    always_comb begin
        w_count = '0;
        w_first = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_count = w_count + CW'(w_obj_nxt[i]);
            if (w_obj_nxt[i]) w_first = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
        end else begin
            r_count <= w_count;
            r_first <= w_first;
            r_any   <= |w_obj_nxt;
        end
    end

    assign obj_count  = r_count;
    assign first_idx  = r_first;
    assign any_object = r_any;
endmodule

// File: tb/tb_obj_fsm_multi.sv
// Directed-vector bench for obj_fsm_multi at default parameters.

module tb_obj_fsm_multi;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] det, ch_en, object, obj_rise;
    logic [1:0] obj_count, first_idx;
    logic       any_object;
    int         n_chk = 0;
    int         n_fail = 0;

    obj_fsm_multi dut (
        .clk       (clk),
        .reset     (reset),
        .det       (det),
        .ch_en     (ch_en),
        .object    (object),
        .obj_rise  (obj_rise),
        .obj_count (obj_count),
        .any_object(any_object),
        .first_idx (first_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] obj, input logic [2:0] rise,
                           input logic [1:0] cnt, input logic any, input logic [1:0] idx);
        chk({tag, ".object"}, 32'(object), 32'(obj));
        chk({tag, ".rise"},   32'(obj_rise), 32'(rise));
        chk({tag, ".count"},  32'(obj_count), 32'(cnt));
        chk({tag, ".any"},    32'(any_object), 32'(any));
        chk({tag, ".first"},  32'(first_idx), 32'(idx));
    endtask

    initial begin
        reset = 1'b0;
        det   = 3'b000;
        ch_en = 3'b111;
        tick(2);
        chk_all("reset", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        reset = 1'b1;
        tick();

        // Single channel confirm then release on 4th low edge
        det = 3'b001;
        tick();
        chk_all("c0_e1", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        tick();
        chk_all("c0_e2", 3'b001, 3'b001, 2'd1, 1'b1, 2'd0);
        det = 3'b000;
        tick();
        chk_all("c0_low1", 3'b001, 3'b000, 2'd1, 1'b1, 2'd0);
        tick(2);
        chk("c0_low3.object", 32'(object), 32'h1);
        tick();
        chk_all("c0_low4", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);

        // One-sample glitch is rejected
        det = 3'b010;
        tick();
        chk_all("glitch_e1", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        det = 3'b000;
        tick();
        chk_all("glitch_e2", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);

        // Brief drop inside hold window: no second rise
        det = 3'b100;
        tick(2);
        chk_all("c2_conf", 3'b100, 3'b100, 2'd1, 1'b1, 2'd2);
        det = 3'b000;
        tick(2);
        chk_all("c2_hold", 3'b100, 3'b000, 2'd1, 1'b1, 2'd2);
        det = 3'b100;
        tick();
        chk_all("c2_reacq", 3'b100, 3'b000, 2'd1, 1'b1, 2'd2);
        det = 3'b000;
        tick(4);
        chk("c2_rel.object", 32'(object), 32'h0);

        // Simultaneous confirms on all channels
        det = 3'b111;
        tick();
        chk("all_e1.object", 32'(object), 32'h0);
        tick();
        chk_all("all_conf", 3'b111, 3'b111, 2'd3, 1'b1, 2'd0);
        det = 3'b000;
        tick(4);
        chk_all("all_rel", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);

        // Nonzero first_idx as lower channels release
        det = 3'b110;
        tick(2);
        chk_all("c12_conf", 3'b110, 3'b110, 2'd2, 1'b1, 2'd1);
        det = 3'b100;
        tick(3);
        chk("c12_low3.object", 32'(object), 32'h6);
        tick();
        chk_all("c1_rel", 3'b100, 3'b000, 2'd1, 1'b1, 2'd2);
        det = 3'b000;
        tick(4);
        chk("c2_rel2.object", 32'(object), 32'h0);

        // Channel disable overrides det; re-enable reconfirms from IDLE
        det = 3'b001;
        tick(2);
        chk_all("en_conf", 3'b001, 3'b001, 2'd1, 1'b1, 2'd0);
        ch_en = 3'b110;
        tick();
        chk_all("en_off", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        tick();
        chk("en_off2.object", 32'(object), 32'h0);
        ch_en = 3'b111;
        tick();
        chk_all("en_on1", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        tick();
        chk_all("en_on2", 3'b001, 3'b001, 2'd1, 1'b1, 2'd0);

        // Asynchronous reset between edges, then full re-debounce
        #3 reset = 1'b0;
        #2;
        chk_all("async_rst", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        #1 reset = 1'b1;
        tick();
        chk_all("post_rst1", 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
        tick();
        chk_all("post_rst2", 3'b001, 3'b001, 2'd1, 1'b1, 2'd0);
        tick();
        chk_all("post_rst3", 3'b001, 3'b000, 2'd1, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
